// File: rtl/uart_spi_bridge.sv
// uart_spi_bridge: byte-command UART front end for an external SPI master.
// The host issues one-byte commands and gets one-byte replies. It can drive
// chip selects and stream counted SPI transfers, with echo or write-only data.
//
// state | meaning
// CMD   | waiting for a command byte
// COUNT | collecting the big-endian transfer count
// DATA  | waiting for the next raw data byte from the host
// SPI   | SPI byte in flight, waiting for spi_txn_done
module uart_spi_bridge #(
  parameter int NUM_CS       = 2,
  parameter int COUNT_BYTES  = 2,
  parameter int UART_DIVIDER = 434
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  output logic [7:0]        spi_data_tx,
  input  logic [7:0]        spi_data_rx,
  output logic              spi_txn_start,
  input  logic              spi_txn_done,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic [11:0]       uart_divider,
  output logic [7:0]        uart_data_tx,
  output logic              uart_have_data_tx,
  input  logic              uart_transmitting,
  input  logic [7:0]        uart_data_rx,
  input  logic              uart_have_data_rx,
  output logic              uart_data_rx_ack,
  output logic              busy
);

  localparam int CW = 8 * COUNT_BYTES;

  typedef enum logic [1:0] {ST_CMD, ST_COUNT, ST_DATA, ST_SPI} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [1:0]    byte_idx;
  logic          wo_mode;
  logic          tx_pending;
  logic [7:0]    tx_byte;

  logic          rx_accept;
  logic          tx_send;
  logic          cs_valid;
  logic [CW-1:0] count_shift;

  assign uart_divider = 12'(UART_DIVIDER);
  assign busy         = (state != ST_CMD) || tx_pending;

  // No RX byte is taken while a reply is queued or the UART is busy, so a
  // reply can never be overwritten; the ack pulse itself blocks the next cycle.
  assign rx_accept   = uart_have_data_rx && !uart_data_rx_ack && !tx_pending &&
                       !uart_transmitting && (state != ST_SPI);
  assign tx_send     = tx_pending && !uart_transmitting && !uart_have_data_tx;
  assign cs_valid    = ({28'd0, uart_data_rx[3:0]} < NUM_CS);
  assign count_shift = (count << 8) | CW'(uart_data_rx);

  // Command FSM, reply holding register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_CMD;
      count             <= '0;
      byte_idx          <= '0;
      wo_mode           <= 1'b0;
      tx_pending        <= 1'b0;
      tx_byte           <= 8'h00;
      spi_data_tx       <= 8'h00;
      spi_txn_start     <= 1'b0;
      spi_cs_n          <= '1;
      uart_data_tx      <= 8'h00;
      uart_have_data_tx <= 1'b0;
      uart_data_rx_ack  <= 1'b0;
    end else if (!active) begin
      spi_txn_start     <= 1'b0;
      uart_have_data_tx <= 1'b0;
      uart_data_rx_ack  <= 1'b0;
    end else begin
      spi_txn_start     <= 1'b0;
      uart_have_data_tx <= 1'b0;
      uart_data_rx_ack  <= 1'b0;

      if (tx_send) begin
        uart_data_tx      <= tx_byte;
        uart_have_data_tx <= 1'b1;
        tx_pending        <= 1'b0;
      end

      case (state)
        ST_CMD: begin
          if (rx_accept) begin
            uart_data_rx_ack <= 1'b1;
            tx_pending       <= 1'b1;
            if (uart_data_rx == 8'h70) begin
              tx_byte <= 8'h50;
            end else if (uart_data_rx == 8'h52) begin
              spi_cs_n <= '1;
              tx_byte  <= 8'h71;
            end else if (uart_data_rx[7:4] == 4'hC || uart_data_rx[7:4] == 4'hD) begin
              if (cs_valid) begin
                // bit 4 separates 0xC_ (assert, drive low) from 0xD_ (release)
                for (int i = 0; i < NUM_CS; i++) begin
                  if (uart_data_rx[3:0] == 4'(i)) spi_cs_n[i] <= uart_data_rx[4];
                end
                tx_byte <= 8'h71;
              end else begin
                tx_byte <= 8'h45;
              end
            end else if (uart_data_rx == 8'h90 || uart_data_rx == 8'h94) begin
              wo_mode  <= uart_data_rx[2];
              byte_idx <= '0;
              tx_byte  <= 8'h91;
              state    <= ST_COUNT;
            end else begin
              tx_byte <= 8'h45;
            end
          end
        end
        ST_COUNT: begin
          if (rx_accept) begin
            uart_data_rx_ack <= 1'b1;
            count            <= count_shift;
            if (byte_idx == 2'(COUNT_BYTES - 1)) begin
              tx_pending <= 1'b1;
              if (count_shift == '0) begin
                tx_byte <= 8'h71;
                state   <= ST_CMD;
              end else begin
                tx_byte <= 8'h92;
                state   <= ST_DATA;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        ST_DATA: begin
          if (rx_accept) begin
            uart_data_rx_ack <= 1'b1;
            spi_data_tx      <= uart_data_rx;
            spi_txn_start    <= 1'b1;
            state            <= ST_SPI;
          end
        end
        ST_SPI: begin
          if (spi_txn_done) begin
            count <= count - CW'(1);
            if (!wo_mode) begin
              tx_byte    <= spi_data_rx;
              tx_pending <= 1'b1;
            end else if (count == CW'(1)) begin
              tx_byte    <= 8'h71;
              tx_pending <= 1'b1;
            end
            state <= (count == CW'(1)) ? ST_CMD : ST_DATA;
          end
        end
        default: state <= ST_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_spi_bridge.sv
// tb_uart_spi_bridge: host/UART/SPI models around uart_spi_bridge, with a
// byte-stream reference model that predicts replies, SPI bytes and CS state.
module tb_uart_spi_bridge;

  localparam int NUM_CS      = 2;
  localparam int COUNT_BYTES = 2;
  localparam int CW          = 8 * COUNT_BYTES;
  localparam int TMO         = 3000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              active = 1'b0;
  logic [7:0]        spi_data_tx;
  logic [7:0]        spi_data_rx;
  logic              spi_txn_start;
  logic              spi_txn_done;
  logic [NUM_CS-1:0] spi_cs_n;
  logic [11:0]       uart_divider;
  logic [7:0]        uart_data_tx;
  logic              uart_have_data_tx;
  logic              uart_transmitting;
  logic [7:0]        uart_data_rx;
  logic              uart_have_data_rx;
  logic              uart_data_rx_ack;
  logic              busy;

  uart_spi_bridge #(
    .NUM_CS(NUM_CS),
    .COUNT_BYTES(COUNT_BYTES),
    .UART_DIVIDER(434)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .active(active),
    .spi_data_tx(spi_data_tx),
    .spi_data_rx(spi_data_rx),
    .spi_txn_start(spi_txn_start),
    .spi_txn_done(spi_txn_done),
    .spi_cs_n(spi_cs_n),
    .uart_divider(uart_divider),
    .uart_data_tx(uart_data_tx),
    .uart_have_data_tx(uart_have_data_tx),
    .uart_transmitting(uart_transmitting),
    .uart_data_rx(uart_data_rx),
    .uart_have_data_rx(uart_have_data_rx),
    .uart_data_rx_ack(uart_data_rx_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  byte unsigned rx_q[$];
  byte unsigned tx_obs[$];
  byte unsigned spi_obs[$];
  byte unsigned exp_tx[$];
  byte unsigned exp_spi[$];

  int busy_max    = 3;
  int tx_busy_cnt = 0;
  int ack_cnt     = 0;
  int b2b_ack     = 0;
  int b2b_tx      = 0;
  int n_sent      = 0;
  int stray_req   = 0;
  int stray_done  = 0;
  logic prev_ack  = 1'b0;
  logic prev_tx   = 1'b0;

  // host side: present queued bytes as a level until acked
  initial begin
    uart_have_data_rx = 1'b0;
    uart_data_rx      = 8'h00;
    forever begin
      @(negedge clk);
      if (uart_have_data_rx && uart_data_rx_ack) begin
        uart_have_data_rx = 1'b0;
      end else if (!uart_have_data_rx && rx_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        uart_data_rx      = rx_q.pop_front();
        uart_have_data_rx = 1'b1;
      end
    end
  end

  // UART transmitter: capture replies, stay busy for a random time
  initial begin
    uart_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_data_rx_ack) ack_cnt++;
      if (uart_data_rx_ack && prev_ack) b2b_ack++;
      if (uart_have_data_tx && prev_tx) b2b_tx++;
      prev_ack = uart_data_rx_ack;
      prev_tx  = uart_have_data_tx;
      if (uart_have_data_tx) begin
        tx_obs.push_back(uart_data_tx);
        tx_busy_cnt = $urandom_range(1, busy_max);
      end else if (tx_busy_cnt > 0) begin
        tx_busy_cnt--;
      end
      uart_transmitting = (tx_busy_cnt > 0);
    end
  end

  // SPI master: record each byte, answer with its complement after a delay
  initial begin
    logic [7:0] sb;
    spi_txn_done = 1'b0;
    spi_data_rx  = 8'h00;
    forever begin
      @(negedge clk);
      if (spi_txn_start) begin
        sb = spi_data_tx;
        spi_obs.push_back(sb);
        repeat ($urandom_range(0, 6)) @(negedge clk);
        spi_data_rx  = ~sb;
        spi_txn_done = 1'b1;
        @(negedge clk);
        spi_txn_done = 1'b0;
      end else if (stray_req != stray_done) begin
        spi_data_rx  = 8'h5A;
        spi_txn_done = 1'b1;
        @(negedge clk);
        spi_txn_done = 1'b0;
        stray_done++;
      end
    end
  end

  // reference model: consumes host bytes, predicts the whole exchange
  int      m_state;
  int      m_cs;
  bit      m_wo;
  longint  m_count;
  int      m_idx;

  task automatic model_reset();
    m_state = 0;
    m_cs    = (1 << NUM_CS) - 1;
    m_wo    = 1'b0;
    m_count = 0;
    m_idx   = 0;
  endtask

  task automatic send(input byte unsigned b);
    int n;
    rx_q.push_back(b);
    n_sent++;
    n = b & 15;
    case (m_state)
      0: begin
        if (b == 8'h70) exp_tx.push_back(8'h50);
        else if (b == 8'h52) begin
          m_cs = (1 << NUM_CS) - 1;
          exp_tx.push_back(8'h71);
        end else if ((b >> 4) == 12 || (b >> 4) == 13) begin
          if (n < NUM_CS) begin
            if ((b >> 4) == 12) m_cs = m_cs & ~(1 << n);
            else m_cs = m_cs | (1 << n);
            exp_tx.push_back(8'h71);
          end else exp_tx.push_back(8'h45);
        end else if (b == 8'h90 || b == 8'h94) begin
          m_wo    = (b == 8'h94);
          m_idx   = 0;
          m_count = 0;
          m_state = 1;
          exp_tx.push_back(8'h91);
        end else exp_tx.push_back(8'h45);
      end
      1: begin
        m_count = ((m_count << 8) | longint'(b)) & ((64'd1 << CW) - 1);
        m_idx++;
        if (m_idx == COUNT_BYTES) begin
          if (m_count == 0) begin
            exp_tx.push_back(8'h71);
            m_state = 0;
          end else begin
            exp_tx.push_back(8'h92);
            m_state = 2;
          end
        end
      end
      default: begin
        exp_spi.push_back(b);
        if (!m_wo) exp_tx.push_back(8'(~b));
        m_count--;
        if (m_count == 0) begin
          if (m_wo) exp_tx.push_back(8'h71);
          m_state = 0;
        end
      end
    endcase
  endtask

  task automatic compare(input string tag);
    check_val({tag, "_ntx"}, tx_obs.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_obs.size(); i++)
      check_val({tag, "_tx"}, tx_obs[i], exp_tx[i]);
    check_val({tag, "_nspi"}, spi_obs.size(), exp_spi.size());
    for (int i = 0; i < exp_spi.size() && i < spi_obs.size(); i++)
      check_val({tag, "_spi"}, spi_obs[i], exp_spi[i]);
    check_val({tag, "_cs"}, spi_cs_n, m_cs);
    tx_obs.delete();
    exp_tx.delete();
    spi_obs.delete();
    exp_spi.delete();
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (t < TMO && !(rx_q.size() == 0 && !uart_have_data_rx && !busy &&
                        !uart_have_data_tx && tx_obs.size() >= exp_tx.size())) begin
      @(negedge clk);
      t++;
    end
    check_val({tag, "_timeout"}, (t >= TMO), 0);
    repeat (4) @(negedge clk);
    check_val({tag, "_busy"}, busy, 0);
    compare(tag);
  endtask

  task automatic send_xfer(input bit wo, input int n);
    send(wo ? 8'h94 : 8'h90);
    for (int i = COUNT_BYTES - 1; i >= 0; i--) send(8'((n >> (8 * i)) & 255));
    for (int i = 0; i < n; i++) send(8'($urandom_range(0, 255)));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int acks_before;
    int k;
    byte unsigned b;

    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_cs", spi_cs_n, (1 << NUM_CS) - 1);
    check_val("rst_spi_data", spi_data_tx, 0);
    check_val("rst_uart_data", uart_data_tx, 0);
    check_val("rst_start", spi_txn_start, 0);
    check_val("rst_have_tx", uart_have_data_tx, 0);
    check_val("rst_ack", uart_data_rx_ack, 0);
    check_val("rst_busy", busy, 0);
    check_val("divider", uart_divider, 434);

    rst_n  = 1'b1;
    active = 1'b1;
    @(negedge clk);

    send(8'h70);
    drain("ping");

    send(8'hC1);
    drain("cs_c1");
    check_val("cs_c1_val", spi_cs_n, 2'b01);
    send(8'hC5);
    drain("cs_c5");
    check_val("cs_c5_val", spi_cs_n, 2'b01);
    send(8'h52);
    drain("cs_52");
    check_val("cs_52_val", spi_cs_n, 2'b11);

    busy_max = 20;
    send(8'h90); send(8'h00); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33);
    drain("echo");

    busy_max = 3;
    send(8'h94); send(8'h00); send(8'h02); send(8'hAB); send(8'hCD);
    drain("wo");

    busy_max = 25;
    send(8'h90); send(8'h00); send(8'h00);
    drain("zero");
    busy_max = 3;

    stray_req++;
    repeat (12) @(negedge clk);
    check_val("stray_busy", busy, 0);
    check_val("stray_ntx", tx_obs.size(), 0);
    drain("stray");

    active      = 1'b0;
    acks_before = ack_cnt;
    send(8'h70);
    repeat (20) @(negedge clk);
    check_val("inactive_ack", ack_cnt - acks_before, 0);
    check_val("inactive_ntx", tx_obs.size(), 0);
    active = 1'b1;
    drain("inactive");

    send(8'hC0);
    drain("pre_mid");
    send(8'h90); send(8'h00); send(8'h05); send(8'h3C); send(8'hA5);
    t = 0;
    while (t < TMO && !(spi_obs.size() >= 2 && tx_obs.size() >= exp_tx.size() &&
                        rx_q.size() == 0 && !uart_have_data_rx)) begin
      @(negedge clk);
      t++;
    end
    check_val("mid_timeout", (t >= TMO), 0);
    repeat (3) @(negedge clk);
    check_val("mid_busy", busy, 1);
    compare("mid");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("mid_rst_cs", spi_cs_n, 2'b11);
    check_val("mid_rst_busy", busy, 0);
    model_reset();
    send(8'h70);
    drain("post_rst");

    for (int it = 0; it < 40; it++) begin
      busy_max = $urandom_range(1, 8);
      k = $urandom_range(0, 5);
      case (k)
        0: send(8'h70);
        1: send(8'h52);
        2: send(8'(($urandom_range(0, 1) ? 8'hD0 : 8'hC0) | $urandom_range(0, 15)));
        3: begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h90 || b == 8'h94) b = 8'h70;
          send(b);
        end
        default: send_xfer(1'($urandom_range(0, 1)), $urandom_range(0, 4));
      endcase
      drain($sformatf("rnd%0d", it));
    end

    check_val("ack_total", ack_cnt, n_sent);
    check_val("ack_b2b", b2b_ack, 0);
    check_val("tx_b2b", b2b_tx, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
